// File: rtl/arith_pkg.sv
// Shared arithmetic-unit definitions: divider FSM states, NZVC flag bit
// positions and the quotient reported on divide errors.
package arith_pkg;
    typedef enum logic [1:0] {IDLE, CALC, DONE} div_state_e;

    localparam int N_BIT = 3;
    localparam int Z_BIT = 2;
    localparam int V_BIT = 1;
    localparam int C_BIT = 0;

    localparam logic [7:0] DIV_ERR_Q = 8'hFF;
endpackage

// File: rtl/seq_divider_16x8_div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder and subtract the divisor when it fits.
module div_step #(
    parameter int W = 8
) (
    input  logic [W:0]   r_in,
    input  logic         q_msb,
    input  logic [W-1:0] divisor,
    output logic [W:0]   r_out,
    output logic         q_bit
);
    logic [W:0] shifted;
    logic [W:0] diff;

    // Full-width compare keeps the trial subtract exact even if r_in[W] were set.
    assign q_bit   = {r_in, q_msb} >= {2'b00, divisor};
    assign shifted = {r_in[W-1:0], q_msb};
    assign diff    = shifted - {1'b0, divisor};
    assign r_out   = q_bit ? diff : shifted;
endmodule

// File: rtl/seq_divider_16x8.sv
// Multi-cycle unsigned restoring divider, 2W-bit dividend by W-bit divisor,
// with start/busy/done handshake and NZVC flags.
module seq_divider_16x8
    import arith_pkg::*;
#(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [2*W-1:0] dividend,
    input  logic [W-1:0]   divisor,
    output logic           busy,
    output logic           done,
    output logic [W-1:0]   quotient,
    output logic [W-1:0]   remainder,
    output logic [3:0]     NZVC
);
    localparam int CW = $clog2(W);

    div_state_e    state, state_nxt;
    logic [W:0]    r;
    logic [W-1:0]  q;
    logic [W-1:0]  dvsr;
    logic [CW-1:0] cnt;
    logic [W:0]    r_step;
    logic          q_bit;
    logic [W-1:0]  q_next;
    logic          op_err;
    logic          last;
    logic [3:0]    err_flags;
    logic [3:0]    ok_flags;

    // divisor==0 is covered too, since any high byte is >= 0.
    assign op_err = dividend[2*W-1:W] >= divisor;
    assign last   = cnt == '0;
    assign q_next = {q[W-2:0], q_bit};

    div_step #(.W(W)) u_step (
        .r_in    (r),
        .q_msb   (q[W-1]),
        .divisor (dvsr),
        .r_out   (r_step),
        .q_bit   (q_bit)
    );

    always_comb begin
        err_flags        = '0;
        err_flags[N_BIT] = DIV_ERR_Q[7];
        err_flags[Z_BIT] = DIV_ERR_Q == '0;
        err_flags[V_BIT] = 1'b1;
        err_flags[C_BIT] = divisor == '0;
        ok_flags         = '0;
        ok_flags[N_BIT]  = q_next[W-1];
        ok_flags[Z_BIT]  = q_next == '0;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = state != IDLE;
        done      = state == DONE;
        case (state)
            IDLE:    if (start) state_nxt = op_err ? DONE : CALC;
            CALC:    if (last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r         <= '0;
            q         <= '0;
            dvsr      <= '0;
            cnt       <= '0;
            quotient  <= '0;
            remainder <= '0;
            NZVC      <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    dvsr <= divisor;
                    if (op_err) begin
                        quotient  <= W'(DIV_ERR_Q);
                        remainder <= '0;
                        NZVC      <= err_flags;
                    end else begin
                        r   <= {1'b0, dividend[2*W-1:W]};
                        q   <= dividend[W-1:0];
                        cnt <= CW'(W-1);
                    end
                end
                CALC: begin
                    r   <= r_step;
                    q   <= q_next;
                    cnt <= cnt - 1'b1;
                    if (last) begin
                        quotient  <= q_next;
                        remainder <= r_step[W-1:0];
                        NZVC      <= ok_flags;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/seq_divider_16x8.md
Name: seq_divider_16x8

Overview:
- Multi-cycle unsigned restoring divider. It divides a 16-bit dividend by an 8-bit divisor and produces an 8-bit quotient and an 8-bit remainder.
- It is the inverse of the 8x8 multiplier: a 16-bit product P divided by one factor returns the other factor with remainder 0.
- It sits in the arithmetic unit beside the adder/subtractor and multiplier.
- It runs a start/busy/done handshake so the control FSM can stall on it. Flags use the same [N,Z,V,C] layout as the rest of the arithmetic unit.

Parameters:
- W, 8, quotient/divisor/remainder width. The dividend is 2*W. Only W=8 is verified.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request pulse. Sampled only when busy=0.
- dividend  input  16  numerator. Sampled on the accepted start.
- divisor  input  8  denominator. Sampled on the accepted start.
- busy  output  1  high while an operation is in progress, including the done cycle.
- done  output  1  single-cycle pulse. Results and flags are valid from this cycle on.
- quotient  output  8  registered quotient.
- remainder  output  8  registered remainder.
- NZVC  output  4  registered flags [N,Z,V,C].

Behaviour:
- Reset: one clock, synchronous, active-high. On rst=1 at a rising edge:
  - state goes to IDLE;
  - busy=0, done=0, quotient=0, remainder=0, NZVC=4'b0000;
  - internal shift registers and counter are cleared.
- Reset mid-operation:
  - the operation is aborted, with no done pulse;
  - rst has priority over start.
- States: IDLE, CALC, DONE.
- IDLE, no start: outputs hold their last results.
- IDLE, start=1, error case (accepted at edge t):
  - operands are latched;
  - error check: divisor==0 (div0), or dividend[15:8] >= divisor (quotient overflow);
  - next state is DONE.
- IDLE, start=1, no error (accepted at edge t):
  - 9-bit partial remainder R = {0, dividend[15:8]};
  - shift register Q = dividend[7:0];
  - counter = 7;
  - next state is CALC.
- CALC (one quotient bit per cycle, MSB first):
  - T = {R[7:0], Q[7]} - {0, divisor}, 9 bits;
  - if T is non-negative: R = T and shift 1 into Q;
  - otherwise: R = {R[7:0], Q[7]} and shift 0 into Q;
  - the counter decrements; after the counter=0 iteration, go to DONE.
- DONE:
  - quotient, remainder and NZVC are written on the edge entering DONE;
  - done=1 for exactly this cycle;
  - next state is IDLE.
- Latency:
  - normal: start at edge t, 8 CALC cycles, done high in cycle t+9;
  - error: done high in cycle t+1.
- busy: 1 in CALC and DONE, 0 in IDLE.
- start while busy=1 (including the DONE cycle): ignored, and no queueing.
- Back-to-back: a start can be accepted in the first IDLE cycle after done.
- Error results:
  - quotient=8'hFF, remainder=8'h00;
  - V=1;
  - C=1 only for div0 (C=0 for quotient overflow);
  - N and Z are computed from 8'hFF, so N=1, Z=0.
- Flags, normal case:
  - N = quotient[7];
  - Z = (quotient==0);
  - V = 0;
  - C = 0.
- Widths: the internal remainder is 9 bits to hold the trial-subtract borrow. The final remainder is R[7:0], always < divisor.
- Operands are latched: input changes after acceptance have no effect on the operation in flight.

Decomposition:
- Shared package arith_pkg holds:
  - the state enum (IDLE, CALC, DONE);
  - NZVC bit-index constants: N=3, Z=2, V=1, C=0;
  - the error-quotient constant DIV_ERR_Q = 8'hFF.
- One natural sub-module: div_step. It is the combinational single-iteration trial subtract (R, Q MSB, divisor -> next R, quotient bit). It can be reused by a future unrolled divider.

Test Plan:
- Basic divide: dividend=16'h03E8, divisor=8'h0A, start at t -> done at t+9, quotient=8'h64, remainder=8'h00, NZVC=4'b0000, busy high t+1..t+9.
- Remainder path and max values:
  - 16'h00FF / 8'h10 -> quotient=8'h0F, remainder=8'h0F, NZVC=4'b0000;
  - 16'hFEFF / 8'hFF -> quotient=8'hFF, remainder=8'hFE, NZVC=4'b1000.
- Errors:
  - 16'h1234 / 8'h00 -> done at t+1, quotient=8'hFF, remainder=8'h00, NZVC=4'b1011;
  - 16'h1000 / 8'h10 -> done at t+1, quotient=8'hFF, remainder=8'h00, NZVC=4'b1010.
- Zero and multiplier round-trip:
  - 16'h0000 / 8'h07 -> quotient=0, remainder=0, NZVC=4'b0100;
  - for random A,B (B!=0), feed P=A*B with divisor B -> quotient=A, remainder=0.
- Handshake:
  - start pulsed again at t+3 and during the DONE cycle -> ignored, exactly one done pulse, results from the first operation;
  - a new start one cycle after done is accepted.
- Reset mid-operation: rst asserted at t+4 of a 16'h03E8/8'h0A operation -> next cycle busy=0, done never pulses, quotient=0, remainder=0, NZVC=0; a following start completes correctly.
